// File: rtl/gpio_link_pkg.sv
// rtl/gpio_link_pkg.sv - shared types and GPIO header bit map for the req/ack byte link
package gpio_link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        RD_SETUP,
        ACK_HOLD
    } link_state_t;

    localparam int DATA_LSB = 0;
    localparam int REQ_BIT  = 8;
    localparam int ACK_BIT  = 9;
    localparam int DIR_BIT  = 10;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage flip-flop synchronizer for asynchronous single-bit inputs
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gpio_handshake_responder.sv
// rtl/gpio_handshake_responder.sv - responder side of the four-phase req/ack GPIO byte link
module gpio_handshake_responder
    import gpio_link_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              gpio_req,
    input  logic              gpio_dir,
    input  logic [DATA_W-1:0] gpio_data_in,
    output logic [DATA_W-1:0] gpio_data_out,
    output logic              gpio_data_oe,
    output logic              gpio_ack,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_taken,
    output logic              err_timeout,
    input  logic              err_clear,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SET_W = $clog2(SETUP_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETUP_CYCLES - 1);

    link_state_t       state;
    logic              req_s;
    logic              req_p;
    logic              dir_s;
    logic [DATA_W-1:0] tx_reg;
    logic [DATA_W-1:0] drive_reg;
    logic [CNT_W-1:0]  hold_cnt;
    logic [SET_W-1:0]  setup_cnt;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_req (
        .clk   (CLOCK_50),
        .reset (reset),
        .d     (gpio_req),
        .q     (req_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_dir (
        .clk   (CLOCK_50),
        .reset (reset),
        .d     (gpio_dir),
        .q     (dir_s)
    );

    // drive_reg is frozen for the whole read, so a mid-read tx_load never reaches the pins
    assign gpio_data_out = drive_reg;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state        <= IDLE;
            req_p        <= 1'b0;
            gpio_ack     <= 1'b0;
            gpio_data_oe <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            tx_taken     <= 1'b0;
            err_timeout  <= 1'b0;
            busy         <= 1'b0;
            tx_reg       <= '0;
            drive_reg    <= '0;
            hold_cnt     <= '0;
            setup_cnt    <= '0;
        end else begin
            req_p    <= req_s;
            rx_valid <= 1'b0;
            tx_taken <= 1'b0;
            if (tx_load) begin
                tx_reg <= tx_data;
            end
            if (err_clear) begin
                err_timeout <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (req_s && !req_p) begin
                        busy <= 1'b1;
                        if (dir_s) begin
                            state <= CAPTURE;
                        end else begin
                            state        <= RD_SETUP;
                            drive_reg    <= tx_reg;
                            tx_taken     <= 1'b1;
                            gpio_data_oe <= 1'b1;
                            setup_cnt    <= '0;
                        end
                    end
                end

                CAPTURE: begin
                    rx_data  <= gpio_data_in;
                    rx_valid <= 1'b1;
                    gpio_ack <= 1'b1;
                    hold_cnt <= '0;
                    state    <= ACK_HOLD;
                end

                RD_SETUP: begin
                    if (setup_cnt == SET_LAST) begin
                        gpio_ack <= 1'b1;
                        hold_cnt <= '0;
                        state    <= ACK_HOLD;
                    end else begin
                        setup_cnt <= setup_cnt + 1'b1;
                    end
                end

                ACK_HOLD: begin
                    if (!req_s) begin
                        gpio_ack     <= 1'b0;
                        gpio_data_oe <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else if (hold_cnt == CNT_LAST) begin
                        // Abandon the transfer; a still-high req cannot retrigger without a fresh rise
                        gpio_ack     <= 1'b0;
                        gpio_data_oe <= 1'b0;
                        err_timeout  <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else if (hold_cnt != CNT_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_handshake_responder.sv
// tb/tb_gpio_handshake_responder.sv - randomized self-checking bench for gpio_handshake_responder
module tb_gpio_handshake_responder;

    localparam int DW = 8;
    localparam int SS = 2;
    localparam int SC = 2;
    localparam int TO = 16;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          gpio_req;
    logic          gpio_dir;
    logic [DW-1:0] gpio_data_in;
    logic [DW-1:0] gpio_data_out;
    logic          gpio_data_oe;
    logic          gpio_ack;
    logic [DW-1:0] tx_data;
    logic          tx_load;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          tx_taken;
    logic          err_timeout;
    logic          err_clear;
    logic          busy;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] model_tx;
    int            n_rx = 0;
    int            n_tx = 0;
    int            n_ack = 0;
    logic          ack_q = 1'b0;

    gpio_handshake_responder #(
        .DATA_W         (DW),
        .SYNC_STAGES    (SS),
        .SETUP_CYCLES   (SC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .gpio_req      (gpio_req),
        .gpio_dir      (gpio_dir),
        .gpio_data_in  (gpio_data_in),
        .gpio_data_out (gpio_data_out),
        .gpio_data_oe  (gpio_data_oe),
        .gpio_ack      (gpio_ack),
        .tx_data       (tx_data),
        .tx_load       (tx_load),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_taken      (tx_taken),
        .err_timeout   (err_timeout),
        .err_clear     (err_clear),
        .busy          (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (rx_valid === 1'b1) n_rx <= n_rx + 1;
        if (tx_taken === 1'b1) n_tx <= n_tx + 1;
        if (gpio_ack === 1'b1 && ack_q !== 1'b1) n_ack <= n_ack + 1;
        ack_q <= gpio_ack;
    end

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic load_tx(input logic [DW-1:0] v);
        tx_data  = v;
        tx_load  = 1'b1;
        tick();
        tx_load  = 1'b0;
        model_tx = v;
    endtask

    // One complete initiator transfer; latencies are measured from the cycle req is raised
    task automatic xfer(input bit wr, input logic [DW-1:0] wdata, input int hold,
                        input bit mid_load, input logic [DW-1:0] mid_val);
        logic [DW-1:0] exp;
        logic [DW-1:0] pulse_data;
        int ack_k, oe_k, pulse_k, npulse, fall_k, exp_ack, exp_pulse;
        bit hold_bad, fall_bad;
        exp        = wr ? wdata : model_tx;
        exp_ack    = wr ? SS + 2 : SS + 1 + SC;
        exp_pulse  = wr ? SS + 2 : SS + 1;
        ack_k      = -1;
        oe_k       = -1;
        pulse_k    = -1;
        npulse     = 0;
        pulse_data = '0;
        hold_bad   = 1'b0;
        fall_bad   = 1'b0;
        gpio_dir     = wr;
        gpio_data_in = wr ? wdata : DW'($urandom);
        gpio_req     = 1'b1;
        for (int k = 1; k <= 40 && ack_k < 0; k++) begin
            tick();
            if (gpio_data_oe === 1'b1 && oe_k < 0) oe_k = k;
            if ((wr ? rx_valid : tx_taken) === 1'b1) begin
                npulse++;
                pulse_k    = k;
                pulse_data = wr ? rx_data : gpio_data_out;
            end
            if (gpio_ack === 1'b1) ack_k = k;
        end
        checks++;
        if (ack_k != exp_ack) begin
            errors++;
            $display("FAIL ack_latency wr=%0d got %0d want %0d", wr, ack_k, exp_ack);
        end
        checks++;
        if (npulse != 1 || pulse_k != exp_pulse) begin
            errors++;
            $display("FAIL strobe wr=%0d count %0d at %0d want 1 at %0d", wr, npulse, pulse_k, exp_pulse);
        end
        checks++;
        if (pulse_data !== exp) begin
            errors++;
            $display("FAIL data wr=%0d got %02h want %02h", wr, pulse_data, exp);
        end
        checks++;
        if (oe_k != (wr ? -1 : SS + 1)) begin
            errors++;
            $display("FAIL oe_start wr=%0d got %0d want %0d", wr, oe_k, wr ? -1 : SS + 1);
        end
        for (int i = 0; i < hold; i++) begin
            if (mid_load && i == 0) load_tx(mid_val);
            else tick();
            if (gpio_ack !== 1'b1 || busy !== 1'b1 || gpio_data_oe !== !wr) hold_bad = 1'b1;
            if (!wr && gpio_data_out !== exp) hold_bad = 1'b1;
        end
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL hold wr=%0d ack=%b oe=%b out=%02h want out %02h", wr, gpio_ack, gpio_data_oe, gpio_data_out, exp);
        end
        gpio_req = 1'b0;
        fall_k   = -1;
        for (int k = 1; k <= 40 && fall_k < 0; k++) begin
            tick();
            if (gpio_ack === 1'b0) fall_k = k;
            else if (gpio_data_oe !== !wr) fall_bad = 1'b1;
        end
        checks++;
        if (fall_k != SS + 1 || gpio_data_oe !== 1'b0 || fall_bad) begin
            errors++;
            $display("FAIL release wr=%0d fall at %0d want %0d oe=%b", wr, fall_k, SS + 1, gpio_data_oe);
        end
        gpio_data_in = DW'($urandom);
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy got %b want 0", busy);
        end
    endtask

    task automatic test_reset;
        reset        = 1'b1;
        gpio_req     = 1'b0;
        gpio_dir     = 1'b0;
        gpio_data_in = '0;
        tx_data      = '0;
        tx_load      = 1'b0;
        err_clear    = 1'b0;
        repeat (3) tick();
        checks++;
        if ({gpio_ack, gpio_data_oe, rx_valid, tx_taken, err_timeout, busy} !== 6'b0 ||
            gpio_data_out !== '0 || rx_data !== '0) begin
            errors++;
            $display("FAIL reset_values ack=%b oe=%b rxv=%b tt=%b err=%b busy=%b out=%02h rx=%02h want all 0",
                     gpio_ack, gpio_data_oe, rx_valid, tx_taken, err_timeout, busy, gpio_data_out, rx_data);
        end
        reset    = 1'b0;
        model_tx = '0;
        tick();
    endtask

    task automatic test_write;
        xfer(1'b1, 8'hA5, 2, 1'b0, 8'h00);
    endtask

    task automatic test_read;
        load_tx(8'h3C);
        xfer(1'b0, 8'h00, 2, 1'b0, 8'h00);
    endtask

    task automatic test_mid_read_load;
        load_tx(8'h3C);
        xfer(1'b0, 8'h00, 3, 1'b1, 8'h77);
        xfer(1'b0, 8'h00, 1, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back;
        int rx0, tx0, ack0;
        rx0  = n_rx;
        tx0  = n_tx;
        ack0 = n_ack;
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) begin
                xfer(1'b1, DW'(8'h10 + i), 1, 1'b0, 8'h00);
            end else begin
                load_tx(DW'(8'h10 + i));
                xfer(1'b0, 8'h00, 1, 1'b0, 8'h00);
            end
        end
        #2;
        checks++;
        if (n_rx - rx0 != 3 || n_tx - tx0 != 2 || n_ack - ack0 != 5) begin
            errors++;
            $display("FAIL b2b_pulses rx %0d tx %0d ack %0d want 3 2 5", n_rx - rx0, n_tx - tx0, n_ack - ack0);
        end
    endtask

    task automatic test_random;
        logic [DW-1:0] v;
        bit wr;
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0) load_tx(DW'($urandom));
            wr = 1'($urandom_range(0, 1));
            v  = DW'($urandom);
            xfer(wr, v, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), DW'($urandom));
        end
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL no_spurious_timeout got %b want 0", err_timeout);
        end
    endtask

    task automatic test_timeout;
        int ack_k, n_high, extra;
        ack_k        = -1;
        n_high       = 0;
        extra        = 0;
        gpio_dir     = 1'b1;
        gpio_data_in = DW'($urandom);
        gpio_req     = 1'b1;
        for (int k = 1; k <= 40 && ack_k < 0; k++) begin
            tick();
            if (gpio_ack === 1'b1) ack_k = k;
        end
        for (int k = 0; k < 100 && gpio_ack === 1'b1; k++) begin
            n_high++;
            tick();
        end
        checks++;
        if (n_high != TO) begin
            errors++;
            $display("FAIL timeout_hold got %0d cycles want %0d", n_high, TO);
        end
        checks++;
        if (err_timeout !== 1'b1 || gpio_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flag err=%b oe=%b want 1 0", err_timeout, gpio_data_oe);
        end
        repeat (30) begin
            tick();
            if (gpio_ack !== 1'b0 || busy !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL no_retrigger got %0d active cycles want 0", extra);
        end
        gpio_req = 1'b0;
        repeat (4) tick();
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got %b want 1", err_timeout);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got %b want 0", err_timeout);
        end
    endtask

    task automatic test_reset_mid_read;
        int oe_k;
        oe_k     = -1;
        load_tx(8'h5A);
        gpio_dir = 1'b0;
        gpio_req = 1'b1;
        for (int k = 1; k <= 40 && oe_k < 0; k++) begin
            tick();
            if (gpio_data_oe === 1'b1) oe_k = k;
        end
        reset    = 1'b1;
        gpio_req = 1'b0;
        tick();
        checks++;
        if (oe_k < 0 || gpio_data_oe !== 1'b0 || gpio_ack !== 1'b0 || busy !== 1'b0 || gpio_data_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_read oe_seen=%0d oe=%b ack=%b busy=%b out=%02h want oe/ack/busy/out 0",
                     oe_k, gpio_data_oe, gpio_ack, busy, gpio_data_out);
        end
        reset    = 1'b0;
        model_tx = '0;
        tick();
        xfer(1'b1, 8'h01, 2, 1'b0, 8'h00);
        xfer(1'b0, 8'h00, 1, 1'b0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_mid_read_load();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_handshake_responder.md
# gpio_handshake_responder

Responder end of the four-phase req/ack parallel byte link carried on the DE-series 40-pin GPIO header. A remote initiator (a second board, or a Top driving GPIO in the simulator) writes bytes to the FPGA or reads bytes from it. This block synchronizes the handshake, captures or drives the shared data pins, and raises ack. It sits between the GPIO pin wrapper, which owns the tristate buffers, and user logic: switches feed tx_data, and rx_data feeds LEDR/HEX.

## Interface
- DATA_W, 8: data pins, mapped to GPIO[7:0]
- SYNC_STAGES, 2: flip-flop stages on req and dir (≥2)
- SETUP_CYCLES, 2: cycles data is driven before ack rises on a read (≥1)
- TIMEOUT_CYCLES, 1024: ack-hold limit waiting for req to fall (≥4)
- CLOCK_50  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high
- gpio_req  in  1  initiator request, GPIO[8], asynchronous
- gpio_dir  in  1  GPIO[10]; 1 = initiator writes, 0 = initiator reads; stable while req=1
- gpio_data_in  in  DATA_W  pin values, GPIO[7:0]
- gpio_data_out  out  DATA_W  value to drive on GPIO[7:0]
- gpio_data_oe  out  1  1 = wrapper drives GPIO[7:0]; otherwise high-Z
- gpio_ack  out  1  responder acknowledge, GPIO[9]
- tx_data  in  DATA_W  byte offered for the next read
- tx_load  in  1  1-cycle strobe that loads tx_data into tx_reg
- rx_data  out  DATA_W  last byte written by the initiator
- rx_valid  out  1  1-cycle pulse when rx_data updates
- tx_taken  out  1  1-cycle pulse when a read latches tx_reg
- err_timeout  out  1  sticky; set on ack-hold timeout
- err_clear  in  1  clears err_timeout (timeout set in the same cycle wins)
- busy  out  1  1 in any state except IDLE

## Operation
- req_s and dir_s are the synchronizer outputs. req_p is req_s delayed by one cycle. A rise is req_s=1 and req_p=0.
- States:
  - IDLE: on a rise, go to CAPTURE if dir_s=1, otherwise go to RD_SETUP.
  - CAPTURE: one cycle. rx_data ← gpio_data_in, rx_valid=1, gpio_ack←1. Next state is ACK_HOLD.
  - RD_SETUP:
    - On entry, drive_reg ← tx_reg and tx_taken=1.
    - gpio_data_oe=1 and gpio_data_out=drive_reg.
    - After SETUP_CYCLES cycles in this state, gpio_ack←1 and go to ACK_HOLD.
  - ACK_HOLD:
    - gpio_ack=1. gpio_data_oe stays 1 only if the transfer is a read.
    - When req_s=0: gpio_ack←0 and gpio_data_oe←0, then go to IDLE.
    - Otherwise, once the counter reaches TIMEOUT_CYCLES: gpio_ack←0, gpio_data_oe←0, err_timeout←1, then go to IDLE.
- IDLE needs a fresh rise. A req still high after a timeout does not retrigger.
- tx_reg:
  - Loaded on any tx_load, including mid-read.
  - A mid-read load never changes the pins, because the pins show drive_reg, which is frozen for the whole transfer.
  - Reads with no new load return the previous tx_reg again.
- The counter is clog2(TIMEOUT_CYCLES+1) bits wide, cleared on entry to ACK_HOLD, and saturating.
- Reset mid-transfer: next cycle IDLE, ack=0, oe=0. The initiator sees the ack drop and must restart.

## Timing
- Reset values: gpio_ack=0, gpio_data_oe=0, gpio_data_out=0, rx_data=0, rx_valid=0, tx_taken=0, err_timeout=0, busy=0, tx_reg=0, drive_reg=0.
- All outputs are registered. No combinational path from input to output.
- Write, req pin rise to ack=1: SYNC_STAGES+2 cycles. rx_valid is coincident with ack rising.
- Read, req pin rise to ack=1: SYNC_STAGES+1+SETUP_CYCLES cycles. oe=1 starts SETUP_CYCLES cycles before ack.
- req pin fall to ack=0 and oe=0: SYNC_STAGES+1 cycles, in the same cycle.
- Initiator rules:
  - Data and dir are stable before req rises.
  - Data is held until ack rises.
  - Read data is sampled after ack rises.
  - Data is released only after ack falls.

## Structure
- Package gpio_link_pkg holds:
  - the state enum (IDLE, CAPTURE, RD_SETUP, ACK_HOLD)
  - GPIO bit-index constants: DATA_LSB=0, REQ_BIT=8, ACK_BIT=9, DIR_BIT=10.
- Sub-module sync_ff (parameter STAGES) is used for req and dir.
- Tristate assignment lives in the pin wrapper, not in this block.

## Test plan
- Write: dir=1, data=0xA5, req↑ → rx_valid pulse with rx_data=0xA5, ack=1 at SYNC_STAGES+2 cycles. req↓ → ack=0 three cycles later. oe stays 0 throughout.
- Read: tx_load with 0x3C, dir=0, req↑ → oe=1 and gpio_data_out=0x3C, tx_taken pulses, ack rises SETUP_CYCLES later. req↓ → oe and ack both fall.
- Mid-read load: tx_load 0x77 while in ACK_HOLD of a read of 0x3C → pins stay 0x3C. The next read returns 0x77.
- Timeout: req held high with TIMEOUT_CYCLES=16 → ack drops after 16 hold cycles, err_timeout=1, no retrigger while req stays high. err_clear → 0.
- Reset: assert reset during RD_SETUP → next cycle oe=0, ack=0, busy=0. A fresh write of 0x01 then completes normally.
- Back-to-back: five alternating write/read transfers (0x10–0x14) → each is acked once, with no missed or duplicate rx_valid or tx_taken pulses.
